// File: rtl/fp_recip_seq.sv
// Sequential fixed-point reciprocal: ans = 1.0 / in by restoring division,
// one quotient bit per clock, with start/done handshake and saturation.
module fp_recip_seq #(
  parameter int Q = 16,
  parameter int N = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] in,
  output logic [N-1:0] ans,
  output logic         done,
  output logic         divz,
  output logic         ovf
);

  localparam int QW = 2 * Q + 1;
  localparam int CW = $clog2(QW + 1);
  localparam int MW = (QW > N) ? QW : N;
  localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic            sign_q, sign_d;
  logic [N-1:0]    den_q, den_d;
  logic [N:0]      rem_q, rem_d;
  logic [QW-1:0]   quot_q, quot_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    ans_q, ans_d;
  logic            done_q, done_d;
  logic            divz_q, divz_d;
  logic            ovf_q, ovf_d;

  logic [N+1:0]    t;
  logic [N+1:0]    diff;
  logic            ge;
  logic [MW-1:0]   mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      den_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      ans_q   <= '0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      ans_q   <= ans_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
      ovf_q   <= ovf_d;
    end
  end

  // The numerator 2^(2Q) has a single set bit, at position 2Q.
  assign t    = {rem_q, (cnt_q == CW'(2 * Q))};
  assign diff = t - {2'b00, den_q};
  assign ge   = (t >= {2'b00, den_q});
  assign mag  = MW'(quot_q);

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    den_d   = den_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    ans_d   = ans_q;
    done_d  = done_q;
    divz_d  = divz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          if (in == '0) begin
            ans_d   = MAXP;
            divz_d  = 1'b1;
            ovf_d   = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            sign_d  = in[N-1];
            // The most negative operand wraps to 2^(N-1), which is correct unsigned.
            den_d   = in[N-1] ? (~in + N'(1)) : in;
            rem_d   = '0;
            quot_d  = '0;
            cnt_d   = CW'(2 * Q);
            state_d = ITER;
          end
        end
      end
      ITER: begin
        rem_d  = ge ? diff[N:0] : t[N:0];
        quot_d = {quot_q[QW-2:0], ge};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (mag > MW'(MAXP)) begin
          ans_d = sign_q ? (~MAXP + N'(1)) : MAXP;
          ovf_d = 1'b1;
        end else begin
          ans_d = sign_q ? (~mag[N-1:0] + N'(1)) : mag[N-1:0];
          ovf_d = 1'b0;
        end
        divz_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ans  = ans_q;
  assign done = done_q;
  assign divz = divz_q;
  assign ovf  = ovf_q;

endmodule
